// File: rtl/int_ctrl.sv
// Vectored, fixed-priority, nesting interrupt controller.
// It synchronises the raw lines, tracks pending and in-service state, and presents one registered request.
module int_ctrl #(
  parameter int                N_SRC      = 4,
  parameter int                VEC_W      = 8,
  parameter logic [VEC_W-1:0]  VEC_BASE   = 'h00,
  parameter logic [VEC_W-1:0]  VEC_STRIDE = 'h04
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [N_SRC-1:0]  cfg_wdata,
  output logic [N_SRC-1:0]  cfg_rdata,
  output logic              int_req,
  output logic [VEC_W-1:0]  int_vec,
  input  logic              int_ack,
  input  logic              int_eoi
);

  localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   sync1_q, sync2_q, dly_q;
  logic [N_SRC-1:0]   mask_q, mask_d, mode_q, mode_d;
  logic [N_SRC-1:0]   pend_q, pend_d, isr_q, isr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [VEC_W-1:0]   vec_q, vec_d;

  logic [N_SRC-1:0]   rise, w1c, ack_oh, isr_lo, allowed, elig;
  logic               ack_fire, seen;
  logic [ID_W-1:0]    win_id;
  logic [VEC_W-1:0]   win_vec;

  always_comb begin
    rise     = sync2_q & ~dly_q;
    w1c      = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : '0;
    ack_fire = (state_q == REQ) && int_ack;
    ack_oh   = ack_fire ? (N_SRC'(1) << id_q) : '0;

    // Edge sources latch and clear on ack/W1C (a new edge wins); level sources follow the synchronised line.
    pend_d = (mode_q & (rise | (pend_q & ~w1c & ~ack_oh))) | (~mode_q & sync2_q);

    // EOI retires the lowest set ISR bit before the same-cycle ack adds its own.
    isr_lo = isr_q & (~isr_q + N_SRC'(1));
    isr_d  = (int_eoi ? (isr_q & ~isr_lo) : isr_q) | ack_oh;

    mask_d = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : mask_q;
    mode_d = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : mode_q;
  end

  // Only sources strictly above the highest-priority in-service source may nest.
  always_comb begin
    allowed = '0;
    seen    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      seen       = seen | isr_q[i];
      allowed[i] = ~seen;
    end
    elig   = pend_q & mask_q & allowed;
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win_id = ID_W'(i);
    end
    win_vec = VEC_BASE + VEC_W'(win_id) * VEC_STRIDE;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = REQ;
          id_d    = win_id;
          vec_d   = win_vec;
        end
      end
      REQ: begin
        if (int_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      isr_q   <= '0;
      id_q    <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      isr_q   <= isr_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = mask_q;
      2'd1:    cfg_rdata = mode_q;
      2'd2:    cfg_rdata = pend_q;
      default: cfg_rdata = isr_q;
    endcase
  end

  assign int_req = (state_q == REQ);
  assign int_vec = vec_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, reset-during-request sequence, randomised run against a reference model.
module tb_int_ctrl;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_src;
  logic         cfg_we;
  logic [1:0]   cfg_addr;
  logic [N-1:0] cfg_wdata;
  logic [N-1:0] cfg_rdata;
  logic         int_req;
  logic [7:0]   int_vec;
  logic         int_ack;
  logic         int_eoi;

  int checks   = 0;
  int failures = 0;

  int_ctrl #(.N_SRC(N), .VEC_W(8), .VEC_BASE(8'h20), .VEC_STRIDE(8'h04)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .int_req(int_req), .int_vec(int_vec),
    .int_ack(int_ack), .int_eoi(int_eoi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irq;
    logic       we;
    logic [1:0] addr;
    logic [3:0] wd;
    logic       ack;
    logic       eoi;
    logic       req;
    logic [7:0] vec;
    logic [3:0] rd;
  } step_t;

  step_t tbl[$];

  function automatic void add(input logic [3:0] irq, input logic we, input logic [1:0] addr,
                              input logic [3:0] wd, input logic ack, input logic eoi,
                              input logic req, input logic [7:0] vec, input logic [3:0] rd);
    step_t s;
    s.irq = irq; s.we = we; s.addr = addr; s.wd = wd; s.ack = ack; s.eoi = eoi;
    s.req = req; s.vec = vec; s.rd = rd;
    tbl.push_back(s);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: architectural state plus a history of the raw lines sampled at each edge.
  logic [3:0] m_mask, m_mode, m_pend, m_isr;
  logic [3:0] smp [3];
  logic       m_req;
  int         m_id;
  logic [7:0] m_vec;

  function automatic void model_reset();
    m_mask = 0; m_mode = 0; m_pend = 0; m_isr = 0;
    smp[0] = 0; smp[1] = 0; smp[2] = 0;
    m_req = 0; m_id = 0; m_vec = 0;
  endfunction

  function automatic logic [3:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_mode;
      2'd2:    return m_pend;
      default: return m_isr;
    endcase
  endfunction

  function automatic void model_step();
    logic [3:0] lvl, prev, np, ni;
    int lim, win;
    logic ack_ok;
    lvl  = smp[1];                 // line seen by the synchroniser output
    prev = smp[2];                 // one sample older, for edge detection
    lim = N;
    for (int i = N - 1; i >= 0; i--) if (m_isr[i]) lim = i;
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i] && i < lim) win = i;
    ack_ok = m_req && int_ack;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) begin
        logic clr;
        clr   = (cfg_we && cfg_addr == 2 && cfg_wdata[i]) || (ack_ok && m_id == i);
        np[i] = (lvl[i] && !prev[i]) || (m_pend[i] && !clr);
      end else begin
        np[i] = lvl[i];
      end
    end
    ni = m_isr;
    if (int_eoi && m_isr != 0) ni[lim] = 1'b0;
    if (ack_ok) ni[m_id] = 1'b1;
    if (m_req) begin
      if (int_ack) m_req = 0;
    end else if (win >= 0) begin
      m_req = 1;
      m_id  = win;
      m_vec = 8'(32'h20 + win * 4);
    end
    if (cfg_we && cfg_addr == 0) m_mask = cfg_wdata;
    if (cfg_we && cfg_addr == 1) m_mode = cfg_wdata;
    m_pend = np;
    m_isr  = ni;
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = irq_src;
  endfunction

  initial begin
    reset = 1; irq_src = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; int_ack = 0; int_eoi = 0;

    // Basic edge request
    add(4'h0,1,0,4'hF,0,0, 0,8'h00,4'hF);
    add(4'h0,1,1,4'hF,0,0, 0,8'h00,4'hF);
    add(4'h4,0,2,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h4,0,2,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h4,0,2,4'h0,0,0, 0,8'h00,4'h4);
    add(4'h0,0,2,4'h0,0,0, 1,8'h28,4'h4);
    add(4'h0,0,3,4'h0,1,0, 0,8'h00,4'h4);
    add(4'h0,0,2,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h0,0,3,4'h0,0,1, 0,8'h00,4'h0);
    // Priority and nesting
    add(4'hA,0,2,4'h0,0,0, 0,8'h00,4'h0);
    add(4'hA,0,2,4'h0,0,0, 0,8'h00,4'h0);
    add(4'hA,0,2,4'h0,0,0, 0,8'h00,4'hA);
    add(4'h0,0,2,4'h0,0,0, 1,8'h24,4'hA);
    add(4'h0,0,3,4'h0,1,0, 0,8'h00,4'h2);
    add(4'h0,0,2,4'h0,0,0, 0,8'h00,4'h8);
    add(4'h1,0,2,4'h0,0,0, 0,8'h00,4'h8);
    add(4'h1,0,2,4'h0,0,0, 0,8'h00,4'h8);
    add(4'h1,0,2,4'h0,0,0, 0,8'h00,4'h9);
    add(4'h0,0,2,4'h0,0,0, 1,8'h20,4'h9);
    add(4'h0,0,3,4'h0,1,0, 0,8'h00,4'h3);
    add(4'h0,0,3,4'h0,0,1, 0,8'h00,4'h2);
    add(4'h0,0,3,4'h0,0,1, 0,8'h00,4'h0);
    add(4'h0,0,3,4'h0,0,0, 1,8'h2C,4'h0);
    add(4'h0,0,2,4'h0,1,0, 0,8'h00,4'h0);
    add(4'h0,0,3,4'h0,0,1, 0,8'h00,4'h0);
    // Level mode
    add(4'h0,1,1,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h1,0,2,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h1,0,2,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h1,0,2,4'h0,0,0, 0,8'h00,4'h1);
    add(4'h1,0,2,4'h0,0,0, 1,8'h20,4'h1);
    add(4'h1,0,2,4'h0,1,0, 0,8'h00,4'h1);
    add(4'h1,0,3,4'h0,0,0, 0,8'h00,4'h1);
    add(4'h1,0,3,4'h0,0,1, 0,8'h00,4'h0);
    add(4'h1,0,3,4'h0,0,0, 1,8'h20,4'h0);
    add(4'h0,0,3,4'h0,1,0, 0,8'h00,4'h1);
    add(4'h0,0,2,4'h0,0,0, 0,8'h00,4'h1);
    add(4'h0,0,2,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h0,0,3,4'h0,0,1, 0,8'h00,4'h0);
    add(4'h0,0,3,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h0,0,3,4'h0,0,0, 0,8'h00,4'h0);
    // Masking, W1C colliding with a new edge, held request
    add(4'h0,1,0,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h0,1,1,4'hF,0,0, 0,8'h00,4'hF);
    add(4'h2,0,2,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h2,0,2,4'h0,0,0, 0,8'h00,4'h0);
    add(4'h0,0,2,4'h0,0,0, 0,8'h00,4'h2);
    add(4'h0,0,2,4'h0,0,0, 0,8'h00,4'h2);
    add(4'h2,0,2,4'h0,0,0, 0,8'h00,4'h2);
    add(4'h2,0,2,4'h0,0,0, 0,8'h00,4'h2);
    add(4'h0,1,2,4'h2,0,0, 0,8'h00,4'h2);
    add(4'h0,0,2,4'h0,0,0, 0,8'h00,4'h2);
    add(4'h0,1,0,4'h2,0,0, 0,8'h00,4'h2);
    add(4'h0,0,2,4'h0,0,0, 1,8'h24,4'h2);
    add(4'h0,1,0,4'h0,0,0, 1,8'h24,4'h0);
    add(4'h0,1,2,4'h2,0,0, 1,8'h24,4'h0);
    add(4'h0,0,1,4'h0,0,0, 1,8'h24,4'hF);

    repeat (2) @(negedge clk);
    chk("reset_req", int_req, 0);
    chk("reset_vec", int_vec, 0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a); #1;
      chk($sformatf("reset_reg%0d", a), cfg_rdata, 0);
    end
    cfg_addr = 0;
    @(negedge clk);
    reset = 0;

    for (int s = 0; s < tbl.size(); s++) begin
      irq_src = tbl[s].irq; cfg_we = tbl[s].we; cfg_addr = tbl[s].addr;
      cfg_wdata = tbl[s].wd; int_ack = tbl[s].ack; int_eoi = tbl[s].eoi;
      @(negedge clk);
      chk($sformatf("step%0d_req", s), int_req, tbl[s].req);
      if (tbl[s].req) chk($sformatf("step%0d_vec", s), int_vec, tbl[s].vec);
      chk($sformatf("step%0d_rdata", s), cfg_rdata, tbl[s].rd);
    end

    // Reset while a request is outstanding, with an ack arriving at the same time
    irq_src = 0; cfg_we = 0; cfg_wdata = 0; int_eoi = 0;
    int_ack = 1; reset = 1; #1;
    chk("midreset_req", int_req, 0);
    chk("midreset_vec", int_vec, 0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a); #1;
      chk($sformatf("midreset_reg%0d", a), cfg_rdata, 0);
    end
    @(negedge clk);
    reset = 0; int_ack = 0; cfg_addr = 3;
    @(negedge clk);
    chk("midreset_isr_after", cfg_rdata, 0);
    chk("midreset_req_after", int_req, 0);

    // Randomised run against the model
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_req", int_req, m_req);
      if (m_req) chk("rnd_vec", int_vec, m_vec);
      chk("rnd_rdata", cfg_rdata, model_read(cfg_addr));
      if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = 4'($urandom);
      int_ack   = ($urandom_range(0, 2) == 0);
      int_eoi   = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised vectored interrupt controller that generalises the processor's single `interrupcion` input to `N_SRC` independently maskable sources, each configurable as edge- or level-triggered. Sources are fixed-priority and nesting-capable. The block drives a registered request plus a vector to the control unit and tracks in-service state through an acknowledge / end-of-interrupt handshake. It sits between the external interrupt lines and the CPU control unit, and the CPU configures it through a small register port.

## Interface

Parameters:
- `N_SRC`, 4: number of interrupt sources, 1..16; index 0 has the highest priority.
- `VEC_W`, 8: vector width.
- `VEC_BASE`, 8'h00: vector of source 0.
- `VEC_STRIDE`, 8'h04: vector spacing, so vector = `VEC_BASE + id*VEC_STRIDE`, truncated mod 2^VEC_W.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `irq_src` in N_SRC: raw, asynchronous interrupt lines.
- `cfg_we` in 1: register write strobe.
- `cfg_addr` in 2: register select. 0 = MASK (1 = enabled), 1 = MODE (1 = edge, 0 = level), 2 = PEND (read; write-1-to-clear), 3 = ISR (read-only).
- `cfg_wdata` in N_SRC: write data.
- `cfg_rdata` out N_SRC: combinational read of the register at `cfg_addr`.
- `int_req` out 1: registered interrupt request to the control unit.
- `int_vec` out VEC_W: vector of the requested source; valid while `int_req`=1.
- `int_ack` in 1: CPU accepts the request; sampled only while `int_req`=1.
- `int_eoi` in 1: end of interrupt; retires the highest-priority in-service source.

## Operation

- **Reset values:** MASK=0, MODE=0, PEND=0, ISR=0, synchroniser and edge flops=0, `int_req`=0, `int_vec`=0, FSM=IDLE.
- **Synchronisation:** each `irq_src` bit passes through a 2-flop synchroniser followed by a delay flop used for edge detection.
- **Pending, edge mode:** PEND[i] sets on a synchronised 0→1 transition. It clears on `int_ack` for source i or on a CFG write-1-to-clear.
- **Pending, level mode:** PEND[i] = synchronised level. Ack and W1C have no effect. The handler must quiet the source before EOI, or the source re-requests.
- **Eligibility:** source i is eligible when PEND[i] & MASK[i] and i < (index of the lowest set ISR bit, or N_SRC if ISR=0). Only strictly higher priority can nest.
- **Winner:** lowest eligible index.
- **FSM IDLE:** if any source is eligible, latch winner id and vector, set `int_req`=1, go to REQ.
- **FSM REQ:** `int_req` and `int_vec` are held stable even if the source becomes masked or cleared; a request is never retracted. On `int_ack`: set ISR[id], clear PEND[id] if edge-mode, drop `int_req` next cycle, return to IDLE.
- **EOI:** clears the lowest-index set bit of ISR. With ISR=0, EOI is ignored.
- **Simultaneous events:**
  - A set event and a W1C in the same cycle: set wins.
  - Ack and EOI in the same cycle: EOI clears first, then ack sets ISR[id].
  - A W1C of the latched id while in REQ does not drop the request.
- **Config writes:** take effect at the next edge. An eligibility change is seen by the FSM one cycle later.

## Timing

- **Edge-source latency:** `irq_src` is first sampled high at edge k. Synchroniser output is high at k+1, PEND is set at k+2, and `int_req` is high after edge k+3.
- **Ack:** `int_ack` high at edge m → `int_req`=0 after m, ISR set after m. A new request can assert after edge m+1 at the earliest.
- **Back-to-back:** an already-pending eligible source re-requests 1 cycle after ack.
- **Read path:** `cfg_rdata` is combinational with no wait states. A PEND read reflects the registered value.
- **Mid-operation reset:** asserting `reset` during REQ clears `int_req` asynchronously. Any in-flight ack is lost.

## Test plan

- **Basic edge request:** with N_SRC=4, VEC_BASE=0x20, STRIDE=4, write MASK=0xF and MODE=0xF, then pulse `irq_src[2]` high for 3 cycles. Expect `int_req` high 4 edges later with `int_vec`=0x28. On ack, ISR=0x4, PEND=0, and `int_req` low.
- **Priority and nesting:** raise `irq_src[1]` and `irq_src[3]` together. Expect vector 0x24 first; ack it. Expect no request for source 3 while ISR=0x2. Raise `irq_src[0]` and expect vector 0x20 (nested); ack. Send EOI twice, then expect vector 0x2C.
- **Level mode:** set MODE=0 and hold `irq_src[0]` high. Expect request, ack, then ISR=0x1 with PEND still 1. EOI with the source still high → request re-asserts 1 cycle later. Lower the source before the next EOI → no further request.
- **Masking and W1C:** with MASK=0, pulse `irq_src[1]`. Expect PEND=0x2 and no `int_req`. W1C 0x2 in the same cycle as a new edge → PEND stays 0x2. Set MASK=0x2 → request asserts.
- **Held request and reset:** while REQ is asserted for source 2, write MASK=0. Expect `int_req` and `int_vec` unchanged until ack. Assert `reset` mid-REQ → all outputs and registers are 0 immediately.
